// File: rtl/data_sram_resp.sv
// Latency-configurable single-port data SRAM responder for a CPU data port.
// One request at a time: IDLE accepts, WAIT counts LAT cycles, DONE releases stall.
module data_sram_resp #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [3:0]          cnt;
  logic [3:0]          wen_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                accept;
  logic                commit;
  logic                unused_addr;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  // High address bits alias and the byte offset is ignored.
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Next-state, acceptance/commit strobes and the combinational stall.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = WAIT;
          accept     = 1'b1;
          stall      = rst;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        stall = rst;
        // Flush wins over a commit in the same cycle.
        if (flush) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = DONE;
          commit     = 1'b1;
        end else begin
          next_state = WAIT;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, latency counter and captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wen_q   <= 4'd0;
      idx_q   <= {ADDR_W{1'b0}};
      wdata_q <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt     <= 4'(LAT - 1);
        wen_q   <= wen;
        idx_q   <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
      end else if ((state == WAIT) && !flush && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Registered read data and saturating commit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= 32'd0;
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (commit) begin
      if (wen_q == 4'd0) begin
        rdata <= mem[idx_q];
        if (rd_cnt != 16'hFFFF) begin
          rd_cnt <= rd_cnt + 16'd1;
        end
      end else begin
        if (wr_cnt != 16'hFFFF) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
      end
    end
  end

  // Array write port; contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (commit && (wen_q != 4'd0)) begin
      for (int b = 0; b < 4; b++) begin
        if (wen_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: the driver pushes expected responses,
// a negedge monitor pops one whenever a stall burst ends and compares.
module tb_data_sram_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] rdata;
    logic [15:0] rc;
    logic [15:0] wc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   passes  = 0;
  int   run_len = 0;

  data_sram_resp #(.ADDR_W(8), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
    .flush(flush), .rdata(rdata), .stall(stall), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input string name, input int len, input logic [31:0] er,
                      input logic [15:0] erc, input logic [15:0] ewc);
    exp_t e;
    e.name = name; e.len = len; e.rdata = er; e.rc = erc; e.wc = ewc;
    sb.push_back(e);
  endtask

  // A response is the cycle where stall drops after a high burst.
  always @(negedge clk) begin
    if (stall) begin
      run_len++;
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp: stall burst of %0d with no request pending", run_len);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "/stall_len"}, 32'(run_len), 32'(mon_e.len));
        chk({mon_e.name, "/rdata"}, rdata, mon_e.rdata);
        chk({mon_e.name, "/rd_cnt"}, {16'd0, rd_cnt}, {16'd0, mon_e.rc});
        chk({mon_e.name, "/wr_cnt"}, {16'd0, wr_cnt}, {16'd0, mon_e.wc});
      end
      run_len = 0;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 20);
    if (n >= 20) begin
      checks++;
      $display("FAIL %s/timeout: stall high for %0d cycles, expected low", name, n);
    end
  endtask

  task automatic req(input string name, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input bit fl, input int elen,
                     input logic [31:0] er, input logic [15:0] erc, input logic [15:0] ewc);
    push(name, elen, er, erc, ewc);
    en = 1'b1; wen = w; addr = a; wdata = d;
    if (fl) begin
      @(posedge clk); #1;
      flush = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0; wen = 4'd0;
    end else begin
      wait_done(name);
      // en stays high through DONE; it must not start a second access.
      @(posedge clk); #1;
      en = 1'b0; wen = 4'd0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; wen = 4'd0; addr = 32'h10; wdata = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/stall", {31'd0, stall}, 32'd0);
    chk("reset/rdata", rdata, 32'd0);
    chk("reset/rd_cnt", {16'd0, rd_cnt}, 32'd0);
    chk("reset/wr_cnt", {16'd0, wr_cnt}, 32'd0);
    en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    req("wr_full",    4'hF,    32'h10,       32'hDEADBEEF, 1'b0, LAT+1, 32'h00000000, 16'd0, 16'd1);
    req("rd_full",    4'h0,    32'h10,       32'h0,        1'b0, LAT+1, 32'hDEADBEEF, 16'd1, 16'd1);
    req("wr_byte1",   4'b0010, 32'h10,       32'h00005500, 1'b0, LAT+1, 32'hDEADBEEF, 16'd1, 16'd2);
    req("rd_byte1",   4'h0,    32'h10,       32'h0,        1'b0, LAT+1, 32'hDEAD55EF, 16'd2, 16'd2);
    req("wr_flushed", 4'hF,    32'h10,       32'h11111111, 1'b1, LAT,   32'hDEAD55EF, 16'd2, 16'd2);
    req("rd_postfl",  4'h0,    32'h10,       32'h0,        1'b0, LAT+1, 32'hDEAD55EF, 16'd3, 16'd2);
    req("wr_w5",      4'hF,    32'h14,       32'h12345678, 1'b0, LAT+1, 32'hDEAD55EF, 16'd3, 16'd3);
    req("wr_w5_1001", 4'b1001, 32'h17,       32'hAABBCCDD, 1'b0, LAT+1, 32'hDEAD55EF, 16'd3, 16'd4);
    req("rd_w5_hi",   4'h0,    32'hFFFFFC14, 32'h0,        1'b0, LAT+1, 32'hAA3456DD, 16'd4, 16'd4);
    req("rd_alias",   4'h0,    32'h410,      32'h0,        1'b0, LAT+1, 32'hDEAD55EF, 16'd5, 16'd4);

    // Reset lands in the last WAIT cycle of a write; the write must be lost.
    push("rst_abort", LAT, 32'h0, 16'd0, 16'd0);
    en = 1'b1; wen = 4'hF; addr = 32'h10; wdata = 32'h22222222;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_abort/stall_now", {31'd0, stall}, 32'd0);
    en = 1'b0; wen = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req("rd_after_rst", 4'h0, 32'h10, 32'h0, 1'b0, LAT+1, 32'hDEAD55EF, 16'd1, 16'd0);

    // A request held across reset release is accepted fresh from IDLE.
    rst = 1'b0;
    en = 1'b1; wen = 4'h0; addr = 32'h14;
    push("rd_held_rst", LAT+1, 32'hAA3456DD, 16'd1, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_done("rd_held_rst");
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
